// File: rtl/byte_word_packer_if.sv
// byte_word_packer_if: byte-stream handshake plus the word-buffer write port
interface byte_word_packer_if;
  logic in_valid;
  logic [7:0] in_byte;
  logic in_ready;
  logic flush;
  logic buffer_full;
  logic [15:0] data_1;
  logic data_1_en;
  modport master(output in_valid, in_byte, flush, buffer_full, input in_ready, data_1, data_1_en);
  modport slave(input in_valid, in_byte, flush, buffer_full, output in_ready, data_1, data_1_en);
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: pairs a handshaked byte stream into 16-bit buffer writes, with padded odd-byte flush
module byte_word_packer #(
  parameter bit HI_FIRST = 1'b1,
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int CNT_W = 16
) (
  input logic clk_1,
  input logic rst,
  byte_word_packer_if.slave bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic busy
);
  localparam logic [1:0] EMPTY = 2'd0, HALF = 2'd1, PEND = 2'd2;
  logic [1:0] state, state_nx;
  logic [7:0] hold, second;
  logic [15:0] pend_word, pair_word;
  logic complete, emit;
  always_comb begin
    second = bus.in_valid ? bus.in_byte : PAD_BYTE;
    pair_word = HI_FIRST ? {hold, second} : {second, hold};
    // a simultaneous flush is absorbed by the pair; in_valid selects the real byte above
    complete = state == HALF && (bus.in_valid || bus.flush);
    emit = (complete || state == PEND) && !bus.buffer_full;
    state_nx = state == EMPTY ? (bus.in_valid ? HALF : EMPTY) :
               state == PEND ? (bus.buffer_full ? PEND : EMPTY) :
               complete ? (bus.buffer_full ? PEND : EMPTY) : HALF;
  end
  assign bus.in_ready = state != PEND;
  assign busy = state != EMPTY;
  always_ff @(posedge clk_1 or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      hold <= '0;
      pend_word <= '0;
      bus.data_1 <= '0;
      bus.data_1_en <= 1'b0;
      word_cnt <= '0;
    end else begin
      state <= state_nx;
      bus.data_1_en <= emit;
      if (emit) begin
        bus.data_1 <= state == PEND ? pend_word : pair_word;
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (complete && bus.buffer_full) pend_word <= pair_word;
      if (state == EMPTY && bus.in_valid) hold <= bus.in_byte;
    end
endmodule
